// File: rtl/csi2_pkg.sv
// csi2_pkg: data type codes and writer/reader state encodings shared by csi2_line_stream
package csi2_pkg;
   localparam logic [5:0] DT_FS   = 6'h00;
   localparam logic [5:0] DT_FE   = 6'h01;
   localparam logic [5:0] DT_RAW8 = 6'h2A;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;
   typedef enum logic {R_IDLE, R_STREAM} rd_state_e;
endpackage

// File: rtl/csi2_line_bank.sv
// csi2_line_bank: two-bank line RAM with registered read, plus per-bank full flag,
// word count, last-word keep and start-of-frame tag.
module csi2_line_bank #(
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 1024,
   localparam int BYTES = DATA_W / 8,
   localparam int AW    = $clog2(BUF_DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   we_i,
   input  logic [AW:0]            waddr_i,
   input  logic [DATA_W-1:0]      wdata_i,
   input  logic                   re_i,
   input  logic [AW:0]            raddr_i,
   output logic [DATA_W-1:0]      rdata_o,
   input  logic                   commit_i,
   input  logic                   commit_bank_i,
   input  logic                   commit_user_i,
   input  logic [CW-1:0]          commit_words_i,
   input  logic [BYTES-1:0]       commit_keep_i,
   input  logic                   release_i,
   input  logic                   release_bank_i,
   output logic [1:0]             full_o,
   output logic [1:0]             user_o,
   output logic [1:0][CW-1:0]     words_o,
   output logic [1:0][BYTES-1:0]  keep_o
);
   logic [DATA_W-1:0]     mem [2*BUF_DEPTH];
   logic [DATA_W-1:0]     rdata_q;
   logic [1:0]            full_q, user_q;
   logic [1:0][CW-1:0]    words_q;
   logic [1:0][BYTES-1:0] keep_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         full_q  <= '0;
         user_q  <= '0;
         words_q <= '0;
         keep_q  <= '0;
      end else begin
         if (commit_i) begin
            full_q[commit_bank_i]  <= 1'b1;
            user_q[commit_bank_i]  <= commit_user_i;
            words_q[commit_bank_i] <= commit_words_i;
            keep_q[commit_bank_i]  <= commit_keep_i;
         end
         if (release_i) full_q[release_bank_i] <= 1'b0;
      end
   end

   assign rdata_o = rdata_q;
   assign full_o  = full_q;
   assign user_o  = user_q;
   assign words_o = words_q;
   assign keep_o  = keep_q;
endmodule

// File: rtl/csi2_line_stream.sv
// csi2_line_stream: packs CSI-2 payload bytes into a ping-pong line buffer and drains it as AXI4-Stream video.
// Define CSI2_STATS_EN to add the saturating drop_cnt/err_cnt outputs.
module csi2_line_stream
   import csi2_pkg::*;
#(
   parameter int         DATA_W    = 32,
   parameter int         BUF_DEPTH = 1024,
   parameter logic [1:0] VC_SEL    = 2'd0,
   parameter logic [5:0] DT_SEL    = DT_RAW8,
   localparam int BYTES = DATA_W / 8,
   localparam int AW    = $clog2(BUF_DEPTH),
   localparam int CW    = AW + 1,
   localparam int LW    = BYTES > 1 ? $clog2(BYTES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic [5:0]        in_dt,
   input  logic [1:0]        in_vc,
   input  logic [15:0]       in_wc,
   input  logic              in_err,
   input  logic              sp_valid,
   input  logic [5:0]        sp_dt,
   input  logic [1:0]        sp_vc,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic [BYTES-1:0]  m_tkeep,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic              line_drop
`ifdef CSI2_STATS_EN
  ,output logic [15:0]       drop_cnt,
   output logic [15:0]       err_cnt
`endif
);
   wr_state_e             ws_q, ws_d;
   rd_state_e             rs_q, rs_d;
   logic                  wptr_q, wptr_d, drop_q, drop_d, sof_q, sof_d;
   logic [15:0]           wc_q, wc_d, cnt_q, cnt_d;
   logic [LW-1:0]         lane_q, lane_d;
   logic [AW-1:0]         waddr_q, waddr_d, raddr_q, raddr_d, rd_addr;
   logic [DATA_W-1:0]     stg_q, stg_d, word, ram_rdata, tdata_q, tdata_d;
   logic [BYTES-1:0]      keep_last, keep1_q, keep1_d, tkeep_q, tkeep_d;
   logic                  rptr_q, rptr_d, relp_q, relp_d, v1_q, v1_d, last1_q, last1_d, user1_q, user1_d;
   logic                  tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
   logic [1:0]            pend_q, pend_d, bank_full, bank_user;
   logic [1:0][CW-1:0]    bank_words;
   logic [1:0][BYTES-1:0] bank_keep;
   logic                  sop_match, can_fill, byte_ok, we, commit;
   logic                  rd_start, last_rd, adv, re, hs_last;

   always_comb begin
      ws_d = ws_q;
      wptr_d = wptr_q;
      wc_d = wc_q;
      cnt_d = cnt_q;
      lane_d = lane_q;
      waddr_d = waddr_q;
      stg_d = stg_q;
      drop_d = 1'b0;
      commit = 1'b0;
      sop_match = in_sop && in_vc == VC_SEL && in_dt == DT_SEL;
      can_fill = !bank_full[wptr_q] && in_wc != 16'd0 && int'(in_wc) <= BUF_DEPTH * BYTES;
      byte_ok = cnt_q < wc_q;
      we = ws_q == W_FILL && !in_sop && in_valid && byte_ok && (lane_q == LW'(BYTES - 1) || in_eop);
      word = stg_q;
      word[8*lane_q +: 8] = in_data;
      for (int b = 0; b < BYTES; b++) keep_last[b] = b <= int'(lane_q);
      if (in_sop) begin
         // A header mid-line aborts the current line before the new one is judged.
         drop_d = ws_q != W_IDLE;
         ws_d = sop_match ? (can_fill ? W_FILL : W_DROP) : W_IDLE;
         wc_d = in_wc;
         cnt_d = '0;
         lane_d = '0;
         waddr_d = '0;
         stg_d = '0;
      end else if (ws_q == W_FILL && in_valid) begin
         if (byte_ok) begin
            cnt_d = cnt_q + 16'd1;
            stg_d = we ? '0 : word;
            lane_d = we ? '0 : lane_q + 1'b1;
            waddr_d = we ? waddr_q + 1'b1 : waddr_q;
         end
         if (in_eop) begin
            commit = byte_ok && !in_err && cnt_q + 16'd1 == wc_q;
            drop_d = !commit;
            wptr_d = wptr_q ^ commit;
            ws_d = W_IDLE;
         end
      end else if (ws_q == W_DROP && in_valid && in_eop) begin
         drop_d = 1'b1;
         ws_d = W_IDLE;
      end
      sof_d = sp_valid && sp_vc == VC_SEL && sp_dt == DT_FS ? 1'b1 :
              (sp_valid && sp_vc == VC_SEL && sp_dt == DT_FE) || commit ? 1'b0 : sof_q;
   end

   // Two-stage read pipeline: RAM output register, then the AXI output register.
   always_comb begin
      rd_start = rs_q == R_IDLE && bank_full[rptr_q] && pend_q != 2'd2;
      rd_addr = rs_q == R_IDLE ? '0 : raddr_q;
      last_rd = CW'(rd_addr) + 1'b1 == bank_words[rptr_q];
      adv = !tvalid_q || m_tready;
      re = (rd_start || rs_q == R_STREAM) && (!v1_q || adv);
      hs_last = tvalid_q && m_tready && tlast_q;
      rs_d = re ? (last_rd ? R_IDLE : R_STREAM) : rs_q;
      raddr_d = re ? rd_addr + 1'b1 : raddr_q;
      rptr_d = rptr_q ^ (re && last_rd);
      pend_d = pend_q + {1'b0, re && last_rd} - {1'b0, hs_last};
      relp_d = relp_q ^ hs_last;
      v1_d = re || (v1_q && !adv);
      last1_d = re ? last_rd : last1_q;
      user1_d = re ? rd_addr == '0 && bank_user[rptr_q] : user1_q;
      keep1_d = re ? (last_rd ? bank_keep[rptr_q] : '1) : keep1_q;
      tvalid_d = adv ? v1_q : tvalid_q;
      tdata_d = adv && v1_q ? ram_rdata : tdata_q;
      tkeep_d = adv && v1_q ? keep1_q : tkeep_q;
      tuser_d = adv && v1_q ? user1_q : tuser_q;
      tlast_d = adv && v1_q ? last1_q : tlast_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_q <= W_IDLE;
         wptr_q <= 1'b0;
         wc_q <= '0;
         cnt_q <= '0;
         lane_q <= '0;
         waddr_q <= '0;
         stg_q <= '0;
         drop_q <= 1'b0;
         sof_q <= 1'b0;
         rs_q <= R_IDLE;
         rptr_q <= 1'b0;
         raddr_q <= '0;
         pend_q <= '0;
         relp_q <= 1'b0;
         v1_q <= 1'b0;
         last1_q <= 1'b0;
         user1_q <= 1'b0;
         keep1_q <= '0;
         tvalid_q <= 1'b0;
         tdata_q <= '0;
         tkeep_q <= '0;
         tuser_q <= 1'b0;
         tlast_q <= 1'b0;
      end else begin
         ws_q <= ws_d;
         wptr_q <= wptr_d;
         wc_q <= wc_d;
         cnt_q <= cnt_d;
         lane_q <= lane_d;
         waddr_q <= waddr_d;
         stg_q <= stg_d;
         drop_q <= drop_d;
         sof_q <= sof_d;
         rs_q <= rs_d;
         rptr_q <= rptr_d;
         raddr_q <= raddr_d;
         pend_q <= pend_d;
         relp_q <= relp_d;
         v1_q <= v1_d;
         last1_q <= last1_d;
         user1_q <= user1_d;
         keep1_q <= keep1_d;
         tvalid_q <= tvalid_d;
         tdata_q <= tdata_d;
         tkeep_q <= tkeep_d;
         tuser_q <= tuser_d;
         tlast_q <= tlast_d;
      end
   end

   csi2_line_bank #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) u_bank (
      .clk_i(clk), .reset_i(reset),
      .we_i(we), .waddr_i({wptr_q, waddr_q}), .wdata_i(word),
      .re_i(re), .raddr_i({rptr_q, rd_addr}), .rdata_o(ram_rdata),
      .commit_i(commit), .commit_bank_i(wptr_q), .commit_user_i(sof_q),
      .commit_words_i(CW'(waddr_q) + 1'b1), .commit_keep_i(keep_last),
      .release_i(hs_last), .release_bank_i(relp_q),
      .full_o(bank_full), .user_o(bank_user), .words_o(bank_words), .keep_o(bank_keep)
   );

`ifdef CSI2_STATS_EN
   logic [15:0] drop_cnt_q, err_cnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (drop_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (in_valid && in_eop && in_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end
   assign drop_cnt = drop_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

   assign m_tvalid = tvalid_q;
   assign m_tdata = tdata_q;
   assign m_tkeep = tkeep_q;
   assign m_tuser = tuser_q;
   assign m_tlast = tlast_q;
   assign line_drop = drop_q;
endmodule

// File: tb/tb_csi2_line_stream.sv
// tb_csi2_line_stream: directed bench for csi2_line_stream with DATA_W=32
module tb_csi2_line_stream;
   import csi2_pkg::*;
   logic        clk = 1'b0, reset;
   logic        in_valid, in_sop, in_eop, in_err, sp_valid, m_tready;
   logic [7:0]  in_data;
   logic [5:0]  in_dt, sp_dt;
   logic [1:0]  in_vc, sp_vc;
   logic [15:0] in_wc;
   logic        m_tvalid, m_tuser, m_tlast, line_drop;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
`ifdef CSI2_STATS_EN
   logic [15:0] drop_cnt, err_cnt;
`endif
   int          n_tests = 0, n_fail = 0, drops = 0, d0, cyc = 0, e_cyc = 0, first_cyc = -1;
   logic [37:0] beats[$];

   csi2_line_stream dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
      .in_dt(in_dt), .in_vc(in_vc), .in_wc(in_wc), .in_err(in_err),
      .sp_valid(sp_valid), .sp_dt(sp_dt), .sp_vc(sp_vc),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tuser(m_tuser), .m_tlast(m_tlast), .line_drop(line_drop)
`ifdef CSI2_STATS_EN
     ,.drop_cnt(drop_cnt), .err_cnt(err_cnt)
`endif
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Beat observer: records handshakes, drop pulses, and checks stalled beats stay put.
   initial begin
      logic        stall = 1'b0;
      logic [38:0] held = '0;
      forever begin
         @(negedge clk);
         if (reset) stall = 1'b0;
         else begin
            if (stall) check("hold", {m_tvalid, m_tuser, m_tlast, m_tkeep, m_tdata}, held);
            if (m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
            if (m_tvalid && first_cyc < 0) first_cyc = cyc;
            if (line_drop) drops++;
            stall = m_tvalid && !m_tready;
            held = {m_tvalid, m_tuser, m_tlast, m_tkeep, m_tdata};
         end
      end
   end

   function automatic logic [37:0] exp_beat(input int base, input int wc, input int i, input bit u);
      logic [31:0] d = '0;
      logic [3:0]  k = '0;
      for (int b = 0; b < 4; b++)
         if (4*i + b < wc) begin
            d[8*b +: 8] = 8'(base + 4*i + b);
            k[b] = 1'b1;
         end
      return {u, 4*i + 4 >= wc, k, d};
   endfunction

   task automatic send_sp(input logic [5:0] dt);
      @(posedge clk); #1;
      sp_valid = 1'b1; sp_dt = dt; sp_vc = 2'd0;
      @(posedge clk); #1;
      sp_valid = 1'b0;
   endtask

   task automatic send_line(input logic [1:0] vc, input logic [5:0] dt, input int wc, input int nb,
                            input bit err, input int base);
      @(posedge clk); #1;
      in_sop = 1'b1; in_vc = vc; in_dt = dt; in_wc = 16'(wc);
      @(posedge clk); #1;
      in_sop = 1'b0;
      for (int i = 0; i < nb; i++) begin
         in_valid = 1'b1; in_data = 8'(base + i); in_eop = i == nb - 1; in_err = err && i == nb - 1;
         if (i == nb - 1) e_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_eop = 1'b0; in_err = 1'b0;
   endtask

   task automatic wait_beats(input int n, input string tag);
      int t = 0;
      while (beats.size() < n && t < 300) begin
         @(posedge clk);
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
      check(tag, beats.size(), n);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tvalid"}, m_tvalid, 0);
      check({tag, "_tdata"}, m_tdata, 0);
      check({tag, "_tkeep"}, m_tkeep, 0);
      check({tag, "_tuser"}, m_tuser, 0);
      check({tag, "_tlast"}, m_tlast, 0);
      check({tag, "_drop"}, line_drop, 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0; in_data = 0;
      in_dt = 0; in_vc = 0; in_wc = 0; sp_valid = 0; sp_dt = 0; sp_vc = 0; m_tready = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("rst");
      reset = 1'b0;
      m_tready = 1'b1;

      // single 10-byte line with SOF
      send_sp(DT_FS);
      beats.delete(); first_cyc = -1; d0 = drops;
      send_line(2'd0, DT_RAW8, 10, 10, 0, 0);
      wait_beats(3, "t1_cnt");
      for (int i = 0; i < 3; i++) check("t1_beat", beats[i], exp_beat(0, 10, i, i == 0));
      check("t1_lat", first_cyc - e_cyc, 3);
      check("t1_drop", drops - d0, 0);

      // both banks full under backpressure, third line dropped
      m_tready = 1'b0;
      send_sp(DT_FS);
      beats.delete(); d0 = drops;
      send_line(2'd0, DT_RAW8, 16, 16, 0, 'h10);
      send_line(2'd0, DT_RAW8, 16, 16, 0, 'h20);
      send_line(2'd0, DT_RAW8, 16, 16, 0, 'h30);
      repeat (3) @(posedge clk);
      #1;
      check("t2_drop", drops - d0, 1);
      check("t2_stalled", beats.size(), 0);
      m_tready = 1'b1;
      wait_beats(8, "t2_cnt");
      for (int i = 0; i < 4; i++) check("t2_a", beats[i], exp_beat('h10, 16, i, i == 0));
      for (int i = 0; i < 4; i++) check("t2_b", beats[4+i], exp_beat('h20, 16, i, 0));

      // errored line is dropped and leaves SOF pending for the next line
      send_sp(DT_FS);
      beats.delete(); d0 = drops;
      send_line(2'd0, DT_RAW8, 8, 8, 1, 'h40);
      repeat (4) @(posedge clk);
      #1;
      check("t3_drop", drops - d0, 1);
      check("t3_none", beats.size(), 0);
`ifdef CSI2_STATS_EN
      check("t3_err_cnt", err_cnt, 1);
      check("t3_drop_cnt", drop_cnt, 2);
`endif
      send_line(2'd0, DT_RAW8, 8, 8, 0, 'h50);
      wait_beats(2, "t3_cnt");
      for (int i = 0; i < 2; i++) check("t3_beat", beats[i], exp_beat('h50, 8, i, i == 0));

      // FE cancels SOF; ready toggling must not lose or repeat beats
      send_sp(DT_FS);
      send_sp(DT_FE);
      beats.delete();
      send_line(2'd0, DT_RAW8, 16, 16, 0, 'h60);
      for (int i = 0; i < 16; i++) begin
         m_tready = i % 2 == 1;
         @(posedge clk); #1;
      end
      m_tready = 1'b1;
      wait_beats(4, "t4_cnt");
      for (int i = 0; i < 4; i++) check("t4_beat", beats[i], exp_beat('h60, 16, i, 0));

      // ignored packets and a short line
      beats.delete(); d0 = drops;
      send_line(2'd1, DT_RAW8, 8, 8, 0, 0);
      send_line(2'd0, 6'h2B, 8, 8, 0, 0);
      repeat (6) @(posedge clk);
      #1;
      check("t5_ign_beats", beats.size(), 0);
      check("t5_ign_drop", drops - d0, 0);
      send_line(2'd0, DT_RAW8, 12, 11, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      check("t5_short_drop", drops - d0, 1);
      check("t5_short_beats", beats.size(), 0);

      // reset mid-FILL
      d0 = drops;
      send_sp(DT_FS);
      @(posedge clk); #1;
      in_sop = 1'b1; in_vc = 2'd0; in_dt = DT_RAW8; in_wc = 16'd16;
      @(posedge clk); #1;
      in_sop = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("t6_fill");
      reset = 1'b0;

      // reset mid-STREAM while stalled
      m_tready = 1'b0;
      send_sp(DT_FS);
      send_line(2'd0, DT_RAW8, 16, 16, 0, 'h80);
      repeat (4) @(posedge clk);
      #1;
      check("t6_pre_tvalid", m_tvalid, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("t6_stream");
      reset = 1'b0;
      m_tready = 1'b1;
      check("t6_no_drop", drops - d0, 0);
      beats.delete();
      send_sp(DT_FS);
      send_line(2'd0, DT_RAW8, 8, 8, 0, 'h90);
      wait_beats(2, "t6_cnt");
      for (int i = 0; i < 2; i++) check("t6_beat", beats[i], exp_beat('h90, 8, i, i == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/csi2_line_stream.md
# csi2_line_stream

Parametrised CSI-2 receive back end. It takes the byte-serial payload and short-packet events produced by the packet stripper and packs payload bytes into DATA_W-bit words. Each line is held in a two-bank ping-pong line buffer and drained as an AXI4-Stream video stream with full TREADY backpressure, TUSER on start of frame and TLAST on end of line. It replaces the fixed 32-bit, single-line, no-backpressure path between byte-to-pixel and the AXI4-Stream output.

## Interface
- DATA_W, 32: TDATA width; multiple of 8, range 8..128; BYTES = DATA_W/8
- BUF_DEPTH, 1024: words per bank; power of two
- VC_SEL, 0: virtual channel accepted; all other VCs ignored
- DT_SEL, 6'h2A: long-packet data type accepted; other long packets ignored
- clk, in, 1: single clock; all logic rising-edge
- reset, in, 1: asynchronous, active-high
- in_valid, in, 1: in_data carries a payload byte
- in_data, in, 8: payload byte
- in_sop, in, 1: header cycle of a long packet; qualifies in_dt, in_vc, in_wc
- in_eop, in, 1: last payload byte; qualified by in_valid
- in_dt, in, 6: data type
- in_vc, in, 2: virtual channel
- in_wc, in, 16: word count in bytes
- in_err, in, 1: CRC or ECC error; sampled with in_eop
- sp_valid, in, 1: short packet event; qualifies sp_dt and sp_vc
- sp_dt, in, 6: 0x00 FS, 0x01 FE
- sp_vc, in, 2: short packet VC
- m_tvalid, out, 1: AXI4-Stream valid
- m_tready, in, 1: AXI4-Stream ready
- m_tdata, out, DATA_W: packed bytes; first byte in [7:0]
- m_tkeep, out, BYTES: byte enables
- m_tuser, out, 1: start of frame
- m_tlast, out, 1: end of line
- line_drop, out, 1: one-cycle pulse when a line is discarded

## Operation
- Writer states IDLE, FILL, DROP.
  - IDLE -> FILL: in_sop with in_vc==VC_SEL, in_dt==DT_SEL, a free bank, and 0 < in_wc <= BUF_DEPTH*BYTES. On entry, latch in_wc and claim the bank.
  - IDLE -> DROP: in_sop matches VC and DT but no bank is free or in_wc is out of range.
  - Non-matching in_sop: stay IDLE and ignore the payload.
- FILL:
  - Bytes are packed little-endian into a staging word.
  - A word is written when BYTES bytes are collected, or at in_eop.
  - Unused bytes of a partial final word are zero; store a word count and last-word keep per bank.
- FILL, at in_eop:
  - Commit the bank (mark full, record words and keep) only if in_err=0 and the byte count equals the latched wc.
  - Otherwise release the bank and pulse line_drop. Return to IDLE either way.
- In FILL or DROP, a new in_sop before in_eop aborts the current line: release, line_drop pulse, then re-evaluate the sop.
- DROP: discard bytes until in_eop, pulse line_drop, then return to IDLE.
- Banks fill alternately 0,1,0,... A bank is free only when the reader has emitted its TLAST beat.
- Reader states IDLE, STREAM.
  - Reads banks in commit order and emits words 0..n-1.
  - m_tlast=1 on word n-1. m_tkeep is all ones except on the last word, which uses the stored keep.
- TUSER:
  - A pending-SOF flag is set by sp_valid with sp_dt=0x00 and sp_vc==VC_SEL.
  - It is cleared by a matching FE, and bound to the next committed line.
  - m_tuser=1 only on word 0 of that line. A dropped line does not consume the flag.
- Simultaneous commit and reader release of the same bank cannot occur. Simultaneous writer claim and reader release of different banks are both honoured.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tkeep=0, m_tuser=0, m_tlast=0, line_drop=0. Both banks free; writer and reader IDLE; pending-SOF cleared.
- RAM is synchronous read, registered output. First m_tvalid for a line is exactly 3 cycles after the accepted in_eop cycle E (commit at E+1) when the reader is idle.
- AXI rules:
  - Once m_tvalid=1, m_tdata, m_tkeep, m_tuser and m_tlast hold until m_tvalid && m_tready.
  - m_tvalid never drops without a handshake.
  - With m_tready held high, one beat per cycle with no bubbles within a line.
- Consecutive committed lines: at most 2 idle cycles between the TLAST beat and the next word 0.
- Reset mid-line: everything returns to reset state. The partial line is lost; no line_drop pulse.

## Configuration
- CSI2_STATS_EN defined: adds outputs drop_cnt[15:0] and err_cnt[15:0].
  - drop_cnt increments on each line_drop.
  - err_cnt increments on each in_eop with in_err=1.
  - Both saturate at 0xFFFF and reset to 0.
- CSI2_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- csi2_pkg holds:
  - data type constants DT_FS=6'h00, DT_FE=6'h01, DT_RAW8=6'h2A
  - the writer state enum (IDLE/FILL/DROP) and the reader state enum (IDLE/STREAM)
- Sub-module csi2_line_bank: 2×BUF_DEPTH×DATA_W simple dual-port RAM with registered read. It also holds per-bank full flag, word count and last keep.

## Test plan
- FS, then one RAW8 line with wc=10, DATA_W=32, m_tready=1 -> 3 beats, keeps F,F,3; tuser on beat 0 only; tlast on beat 2; bytes 0..9 in order; first tvalid at E+3.
- Two 16-byte lines back to back, m_tready held low until both are committed -> a third sop is dropped (line_drop pulse). Releasing tready then yields 8 beats with tuser only on the first line.
- Line with in_err=1 at eop -> no beats, line_drop, err_cnt=1. The next good line carries tuser.
- m_tready toggling 1,0,1,0 during a 4-beat line -> each beat is held stable while stalled; no loss or duplication.
- Packet with vc=1 or dt=0x2B, or with wc=12 but only 11 bytes before eop -> first two produce no output and no drop; the mismatch produces line_drop.
- reset asserted mid-FILL and mid-STREAM -> all outputs are 0 the next cycle. A fresh FS plus line afterwards streams correctly.
